// File: rtl/pc_update_ctrl_if.sv
// pc_update_ctrl_if: request/acknowledge read port between the PC controller and data memory.
interface pc_update_ctrl_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/pc_update_ctrl.sv
// pc_update_ctrl: owns the PC; single-cycle branches commit at once, memory-indirect forms stall on a read.
module pc_update_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [2:0]         status,
    input  logic [31:0]        alu_result,
    input  logic               alu_zero,
    input  logic [31:0]        pc_plus4,
    input  logic [31:0]        pc_br,
    input  logic [31:0]        reg_s,
    input  logic [31:0]        j_diraddr,
    input  logic [31:0]        mem_addr_in,
    pc_update_ctrl_if.master   mem,
    output logic [31:0]        pc,
    output logic               stall,
    output logic               instr_done,
    output logic               link_we,
    output logic [31:0]        link_data,
    output logic               err
);
    localparam logic [1:0]  IDLE    = 2'd0;
    localparam logic [1:0]  WAIT    = 2'd1;
    localparam logic [1:0]  ERR     = 2'd2;
    localparam logic [15:0] CNT_MAX = 16'(MEM_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, addr_q, addr_d, ret_q, ret_d, br_tgt;
    logic [15:0] cnt_q, cnt_d;
    logic        req_q, req_d, jalm_q, jalm_d, err_q, err_d, mem_path, accept;
    logic        unused_bits;

    assign mem_path = (status == 3'b001 && alu_result[31]) || status == 3'b100 || status == 3'b101;
    assign accept   = state_q == IDLE && instr_valid;
    assign br_tgt   = (status == 3'b010 && alu_zero) ? reg_s :
                      (status == 3'b011 && alu_zero) ? j_diraddr :
                      (status == 3'b110 && alu_zero) ? pc_br : pc_plus4;

    assign pc           = pc_q;
    assign err          = err_q;
    assign stall        = state_q != IDLE;
    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign instr_done   = (accept && !mem_path) || (state_q == WAIT && mem.mem_ack);
    assign link_we      = state_q == WAIT && mem.mem_ack && jalm_q;
    assign link_data    = link_we ? ret_q : 32'd0;
    assign unused_bits  = ^{alu_result[30:0], br_tgt[1:0], mem.mem_rdata[1:0]};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        ret_d   = ret_q;
        jalm_d  = jalm_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (accept && mem_path) begin
            state_d = WAIT;
            req_d   = 1'b1;
            addr_d  = mem_addr_in;
            ret_d   = pc_plus4;
            jalm_d  = status == 3'b101;
            cnt_d   = '0;
        end else if (accept) begin
            pc_d  = {br_tgt[31:2], 2'b00};
            err_d = err_q | (status == 3'b111);
        end else if (state_q == WAIT && mem.mem_ack) begin
            pc_d    = {mem.mem_rdata[31:2], 2'b00};
            req_d   = 1'b0;
            state_d = IDLE;
        end else if (state_q == WAIT && cnt_q == CNT_MAX) begin
            state_d = ERR;
            req_d   = 1'b0;
            err_d   = 1'b1;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Reset also drops mem_req immediately, abandoning any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= '0;
            ret_q   <= '0;
            jalm_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ret_q   <= ret_d;
            jalm_q  <= jalm_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_pc_update_ctrl.sv
// tb_pc_update_ctrl: directed test-plan sequences plus randomized traffic against a behavioural model.
module tb_pc_update_ctrl;
    localparam logic [31:0] RPC = 32'h0000_0040;
    localparam int          TO  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, alu_zero;
    logic [2:0]  status;
    logic [31:0] alu_result, pc_plus4, pc_br, reg_s, j_diraddr, mem_addr_in;
    logic [31:0] pc, link_data;
    logic        stall, instr_done, link_we, err;
    logic        chk_on = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;

    // model state: what the PC/controller must look like, tracked per transaction
    logic [31:0] m_pc, m_addr, m_ret;
    logic        m_busy, m_dead, m_err, m_jalm;
    int          m_waited;

    pc_update_ctrl_if mem_bus();

    pc_update_ctrl #(.RESET_PC(RPC), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .status(status),
        .alu_result(alu_result), .alu_zero(alu_zero), .pc_plus4(pc_plus4), .pc_br(pc_br),
        .reg_s(reg_s), .j_diraddr(j_diraddr), .mem_addr_in(mem_addr_in), .mem(mem_bus),
        .pc(pc), .stall(stall), .instr_done(instr_done), .link_we(link_we),
        .link_data(link_data), .err(err)
    );

    initial forever #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] al(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    function automatic logic is_mem();
        return (status == 3'd1 && alu_result[31]) || status inside {3'd4, 3'd5};
    endfunction

    function automatic logic [31:0] sc_target();
        case (status)
            3'd2:    return alu_zero ? reg_s : pc_plus4;
            3'd3:    return alu_zero ? j_diraddr : pc_plus4;
            3'd6:    return alu_zero ? pc_br : pc_plus4;
            default: return pc_plus4;
        endcase
    endfunction

    function automatic logic exp_done();
        return (!m_busy && !m_dead && instr_valid && !is_mem()) || (m_busy && mem_bus.mem_ack);
    endfunction

    task automatic model_reset();
        m_pc = RPC; m_addr = '0; m_ret = '0;
        m_busy = 1'b0; m_dead = 1'b0; m_err = 1'b0; m_jalm = 1'b0; m_waited = 0;
    endtask

    task automatic model_step();
        if (!rst_n) model_reset();
        else if (m_busy && mem_bus.mem_ack) begin
            m_pc = al(mem_bus.mem_rdata);
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_waited++;
            if (m_waited == TO) begin
                m_busy = 1'b0; m_dead = 1'b1; m_err = 1'b1;
            end
        end else if (!m_dead && instr_valid && is_mem()) begin
            m_busy = 1'b1; m_addr = mem_addr_in; m_ret = pc_plus4;
            m_jalm = status == 3'd5; m_waited = 0;
        end else if (!m_dead && instr_valid) begin
            m_pc = al(sc_target());
            if (status == 3'd7) m_err = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk32("pc", pc, m_pc);
            chk1("stall", stall, m_busy || m_dead);
            chk1("mem_req", mem_bus.mem_req, m_busy);
            if (m_busy) chk32("mem_addr", mem_bus.mem_addr, m_addr);
            chk1("instr_done", instr_done, exp_done());
            chk1("link_we", link_we, m_busy && mem_bus.mem_ack && m_jalm);
            if (m_busy && mem_bus.mem_ack && m_jalm) chk32("link_data", link_data, m_ret);
            chk1("err", err, m_err);
        end
    end

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; status = 3'd0; alu_result = '0; alu_zero = 1'b0;
        pc_plus4 = 32'h44; pc_br = '0; reg_s = '0; j_diraddr = '0; mem_addr_in = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        model_reset();
        tick(); tick();
        chk_on = 1'b1;
        chk32("reset_pc", pc, 32'h40);
        chk1("reset_req", mem_bus.mem_req, 1'b0);
        chk1("reset_stall", stall, 1'b0);
        chk1("reset_err", err, 1'b0);
        rst_n = 1'b1;
        tick(); tick();
        chk32("idle_pc_hold", pc, 32'h40);
        // beq taken, beq not taken, brz with unaligned target
        instr_valid = 1'b1; status = 3'd6; alu_zero = 1'b1; pc_br = 32'h100;
        #1 chk1("beq_done", instr_done, 1'b1);
        tick();
        chk32("beq_taken", pc, 32'h100);
        alu_zero = 1'b0;
        tick();
        chk32("beq_not_taken", pc, 32'h44);
        status = 3'd2; alu_zero = 1'b1; reg_s = 32'h203;
        tick();
        chk32("brz_aligned", pc, 32'h200);
        // bmn taken: ack on the third WAIT cycle; a new instruction is offered but must be ignored
        status = 3'd1; alu_result = 32'h8000_0000; mem_addr_in = 32'h10;
        tick();
        status = 3'd0;
        for (int i = 0; i < 2; i++) begin
            chk1("bmn_req", mem_bus.mem_req, 1'b1);
            chk32("bmn_addr", mem_bus.mem_addr, 32'h10);
            chk1("bmn_stall", stall, 1'b1);
            tick();
        end
        chk32("bmn_pc_frozen", pc, 32'h200);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h300;
        tick();
        mem_bus.mem_ack = 1'b0; instr_valid = 1'b0;
        chk32("bmn_pc", pc, 32'h300);
        chk1("bmn_req_drop", mem_bus.mem_req, 1'b0);
        // bmn not taken
        instr_valid = 1'b1; status = 3'd1; alu_result = 32'h1; pc_plus4 = 32'h304;
        tick();
        chk32("bmn_nt_pc", pc, 32'h304);
        chk1("bmn_nt_req", mem_bus.mem_req, 1'b0);
        // jalm with immediate ack
        status = 3'd5; pc_plus4 = 32'h48; mem_addr_in = 32'h20;
        tick();
        status = 3'd0; mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h500;
        #1 chk1("jalm_link_we", link_we, 1'b1);
        chk32("jalm_link_data", link_data, 32'h48);
        tick();
        mem_bus.mem_ack = 1'b0; instr_valid = 1'b0;
        chk1("jalm_pulse_end", link_we, 1'b0);
        chk32("jalm_pc", pc, 32'h500);
        // jmor timeout
        instr_valid = 1'b1; status = 3'd4; mem_addr_in = 32'h30;
        tick();
        instr_valid = 1'b0;
        for (int i = 0; i < TO - 1; i++) tick();
        chk1("to_not_yet", err, 1'b0);
        tick();
        chk1("to_err", err, 1'b1);
        chk1("to_req", mem_bus.mem_req, 1'b0);
        chk1("to_stall", stall, 1'b1);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h999; instr_valid = 1'b1; status = 3'd0;
        tick(); tick();
        mem_bus.mem_ack = 1'b0; instr_valid = 1'b0;
        chk32("to_late_ack", pc, 32'h500);
        rst_n = 1'b0; model_reset();
        #1 chk1("to_rst_err", err, 1'b0);
        chk1("to_rst_stall", stall, 1'b0);
        tick();
        rst_n = 1'b1;
        // illegal, then a normal branch is still accepted
        instr_valid = 1'b1; status = 3'd7; pc_plus4 = 32'h104;
        tick();
        chk32("ill_pc", pc, 32'h104);
        chk1("ill_err", err, 1'b1);
        status = 3'd6; alu_zero = 1'b1; pc_br = 32'h108;
        tick();
        chk32("ill_next_pc", pc, 32'h108);
        // reset asserted mid-WAIT
        status = 3'd4;
        tick();
        instr_valid = 1'b0;
        #2 rst_n = 1'b0; model_reset();
        #1 chk1("midrst_req", mem_bus.mem_req, 1'b0);
        chk32("midrst_pc", pc, RPC);
        tick();
        rst_n = 1'b1;
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            instr_valid = $urandom_range(0, 3) != 0;
            status = 3'($urandom_range(0, 7));
            alu_result = $urandom; alu_zero = 1'($urandom_range(0, 1));
            pc_plus4 = $urandom; pc_br = $urandom; reg_s = $urandom; j_diraddr = $urandom;
            mem_addr_in = $urandom; mem_bus.mem_rdata = $urandom;
            mem_bus.mem_ack = $urandom_range(0, 4) == 0;
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0; model_reset();
                tick();
                rst_n = 1'b1;
            end else if (m_dead && $urandom_range(0, 3) == 0) begin
                rst_n = 1'b0; model_reset();
                tick();
                rst_n = 1'b1;
            end else tick();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
